logic_unit_arbiter: RTL and testbench



---
 rtl/logic_unit_arbiter.sv | 149 ++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: two-requester round-robin front end for one shared 8-bit
// bitwise logic unit (AND / OR / XOR). Each transaction is accept -> execute ->
// hold response until consumed.
// Optional feature macro: LOGIC_ARB_XNOR_EN (opcode 11 becomes per-bit XNOR;
// without it opcode 11 is reported as unsupported).
module logic_unit_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_id,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       prio_q;      // 0: requester 0 wins a tie, 1: requester 1 wins
    logic       grant0;
    logic       grant1;
    logic       accept;

    // Captured request, valid only between accept and the end of EXEC
    logic [1:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       id_q;

    // Shared logic unit outputs
    logic [7:0] unit_data;
    logic       unit_err;

    // Registered response
    logic [7:0] rsp_data_q;
    logic       rsp_id_q;
    logic       rsp_err_q;

    // Round-robin grant: a lone requester always wins, a tie goes to prio_q
    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~prio_q);
        grant1 = req1_valid & (~req0_valid |  prio_q);
    end

    assign accept = (state_q == IDLE) && (grant0 || grant1);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: clocked blocks use <= so every register samples pre-edge values
        // regardless of statement order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: the default assignment first means no path leaves state_d
        // unassigned, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant0 || grant1) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: readies only in IDLE and never while reset is held
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if ((state_q == IDLE) && !rst) begin
            req0_ready = grant0;
            req1_ready = grant1;
        end
        busy      = (state_q != IDLE);
        rsp_valid = (state_q == RESP);
    end

    // Request capture on the accept edge
    always_ff @(posedge clk) begin
        // NOTE: capture registers have no reset; they are always reloaded on
        // accept before being consumed, and a reset simply abandons them.
        if (accept) begin
            op_q <= grant0 ? req0_op : req1_op;
            a_q  <= grant0 ? req0_a  : req1_a;
            b_q  <= grant0 ? req0_b  : req1_b;
            id_q <= grant1;
        end
    end

    // Shared bitwise unit, driven only by the captured operands
    always_comb begin
        unit_data = 8'h00;
        unit_err  = 1'b0;
        case (op_q)
            2'b00: unit_data = a_q & b_q;
            2'b01: unit_data = a_q | b_q;
            2'b10: unit_data = a_q ^ b_q;
            default: begin
`ifdef LOGIC_ARB_XNOR_EN
                unit_data = ~(a_q ^ b_q);
`else
                unit_err  = 1'b1;
`endif
            end
        endcase
    end

    // Response register: loaded at the end of EXEC, held through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_q <= 8'h00;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_data_q <= unit_data;
            rsp_id_q   <= id_q;
            rsp_err_q  <= unit_err;
        end
    end

    // Priority pointer: the requester just served drops to low priority
    always_ff @(posedge clk) begin
        if (rst)                                prio_q <= 1'b0;
        else if ((state_q == RESP) && rsp_ready) prio_q <= ~rsp_id_q;
    end

    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Testbench for logic_unit_arbiter: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level reference model.
// Honours LOGIC_ARB_XNOR_EN the same way as the design.
module tb_logic_unit_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_id, rsp_err, busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a transaction in flight is just "how far along" it is
    // plus the answer computed at the moment it was accepted.
    int         m_stage = 0;   // 0 none, 1 computing, 2 answer on offer
    logic       m_prio  = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_id    = 1'b0;
    logic       m_err   = 1'b0;

    // Response as observed on the most recent tick
    logic       seen_valid;
    logic [7:0] seen_data;
    logic       seen_id, seen_err;

    logic_unit_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-by-bit evaluation of an opcode; returns {err, data}
    function automatic logic [8:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       e;
        e = 1'b0;
        for (int i = 0; i < 8; i++) begin
            case (op)
                2'b00: r[i] = a[i] & b[i];
                2'b01: r[i] = a[i] | b[i];
                2'b10: r[i] = (a[i] != b[i]);
                default: begin
`ifdef LOGIC_ARB_XNOR_EN
                    r[i] = (a[i] == b[i]);
`else
                    r[i] = 1'b0;
                    e    = 1'b1;
`endif
                end
            endcase
        end
        return {e, r};
    endfunction

    // Who would be served given the current requests: -1 none, else index
    function automatic int pick(input logic v0, input logic v1, input logic p);
        if (v0 && v1) return p ? 1 : 0;
        if (v0)       return 0;
        if (v1)       return 1;
        return -1;
    endfunction

    // One clock: compare at the falling edge, advance the model at the rising edge
    task automatic tick();
        int         w;
        logic [8:0] r;
        @(negedge clk);
        w = -1;
        if (!rst && m_stage == 0) w = pick(req0_valid, req1_valid, m_prio);
        check("req0_ready", req0_ready, (w == 0));
        check("req1_ready", req1_ready, (w == 1));
        check("busy",       busy,       (m_stage != 0));
        check("rsp_valid",  rsp_valid,  (m_stage == 2));
        if (m_stage == 2) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_id",   rsp_id,   m_id);
            check("rsp_err",  rsp_err,  m_err);
        end
        seen_valid = rsp_valid;
        seen_data  = rsp_data;
        seen_id    = rsp_id;
        seen_err   = rsp_err;
        @(posedge clk);
        if (rst) begin
            m_stage = 0;
            m_prio  = 1'b0;
        end else if (m_stage == 0) begin
            w = pick(req0_valid, req1_valid, m_prio);
            if (w >= 0) begin
                r       = (w == 0) ? ref_op(req0_op, req0_a, req0_b) : ref_op(req1_op, req1_a, req1_b);
                m_data  = r[7:0];
                m_err   = r[8];
                m_id    = (w == 1);
                m_stage = 1;
            end
        end else if (m_stage == 1) begin
            m_stage = 2;
        end else if (rsp_ready) begin
            m_prio  = ~m_id;
            m_stage = 0;
        end
        #1;
    endtask

    // Tick until a response is seen (bounded), then check it against fixed values
    task automatic wait_rsp(input string tag, input int exp_lat, input logic exp_id,
                            input logic [7:0] exp_data, input logic exp_err);
        int n = 0;
        seen_valid = 1'b0;
        while (!seen_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, seen_valid, 1'b1);
        check({tag, "_lat"},  n,          exp_lat);
        check({tag, "_id"},   seen_id,    exp_id);
        check({tag, "_data"}, seen_data,  exp_data);
        check({tag, "_err"},  seen_err,   exp_err);
    endtask

    task automatic req0(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic req1(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b0;
        // Contention setup: both requesters valid from reset onward
        req0(1'b1, 2'b10, 8'hAA, 8'h55);
        req1(1'b1, 2'b01, 8'h0F, 8'h10);
        repeat (2) @(posedge clk);
        #1;
        tick();
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_busy",      busy,      1'b0);
        check("reset_rsp_data",  rsp_data,  8'h00);
        check("reset_rsp_id",    rsp_id,    1'b0);
        check("reset_rsp_err",   rsp_err,   1'b0);
        check("reset_ready0",    req0_ready, 1'b0);
        check("reset_ready1",    req1_ready, 1'b0);

        // Contention: six back-to-back transactions alternate 0,1,0,1,...
        rst       = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) wait_rsp("rr0", 3, 1'b0, 8'hFF, 1'b0);
            else            wait_rsp("rr1", 3, 1'b1, 8'h1F, 1'b0);
        end
        req0(1'b0, 2'b00, 8'h00, 8'h00);
        req1(1'b0, 2'b00, 8'h00, 8'h00);
        tick();

        // Single operations from requester 0
        req0(1'b1, 2'b00, 8'hF0, 8'h3C); tick(); req0_valid = 1'b0;
        wait_rsp("and", 2, 1'b0, 8'h30, 1'b0);
        req0(1'b1, 2'b01, 8'hF0, 8'h3C); tick(); req0_valid = 1'b0;
        wait_rsp("or",  2, 1'b0, 8'hFC, 1'b0);
        req0(1'b1, 2'b10, 8'hF0, 8'h3C); tick(); req0_valid = 1'b0;
        wait_rsp("xor", 2, 1'b0, 8'hCC, 1'b0);

        // Opcode 11
        req0(1'b1, 2'b11, 8'h0F, 8'h03); tick(); req0_valid = 1'b0;
`ifdef LOGIC_ARB_XNOR_EN
        wait_rsp("op11", 2, 1'b0, 8'hF3, 1'b0);
`else
        wait_rsp("op11", 2, 1'b0, 8'h00, 1'b1);
`endif

        // Backpressure: five stalled cycles with both requesters pending
        rsp_ready = 1'b0;
        req0(1'b1, 2'b00, 8'hFF, 8'h5A); tick();
        req1(1'b1, 2'b10, 8'h33, 8'h0F);
        wait_rsp("bp", 2, 1'b0, 8'h5A, 1'b0);
        repeat (5) begin
            tick();
            check("bp_hold_data", seen_data, 8'h5A);
        end
        rsp_ready = 1'b1;
        tick();                            // response consumed, requester 0 loses priority
        tick();                            // requester 1 accepted right away
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp("bp_next", 2, 1'b1, 8'h3C, 1'b0);

        // Reset during EXEC, after requester 0 was served so the pointer is set
        req0(1'b1, 2'b01, 8'h01, 8'h02); tick(); req0_valid = 1'b0;
        wait_rsp("pre_rst", 2, 1'b0, 8'h03, 1'b0);
        req0(1'b1, 2'b00, 8'hFF, 8'hFF); tick(); req0_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_exec_busy",  busy,      1'b0);
        check("rst_exec_valid", rsp_valid, 1'b0);
        repeat (4) tick();
        // A tie right after reset must go to requester 0
        req0(1'b1, 2'b10, 8'h81, 8'h01);
        req1(1'b1, 2'b10, 8'h42, 8'h02);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp("post_rst_tie", 2, 1'b0, 8'h80, 1'b0);

        // Reset during RESP
        rsp_ready = 1'b0;
        req1(1'b1, 2'b01, 8'h10, 8'h01); tick(); req1_valid = 1'b0;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_resp_busy",  busy,      1'b0);
        check("rst_resp_valid", rsp_valid, 1'b0);
        rsp_ready = 1'b1;
        repeat (4) tick();

        // Idle hold: lone requester 1 wins with pointer at 0; late operand changes ignored
        req1(1'b1, 2'b00, 8'hC3, 8'h7E); tick();
        req1(1'b0, 2'b11, 8'h00, 8'hFF);
        wait_rsp("idle_r1", 2, 1'b1, 8'h42, 1'b0);

        // Randomized traffic, including occasional reset and backpressure
        for (int c = 0; c < 600; c++) begin
            req0(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 8'($urandom));
            req1(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 8'($urandom));
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
